// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its edge feeders.
package systolic_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;
    localparam int ACC_W  = 32;

    typedef logic signed [DW_DEF-1:0] operand_t;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// DW-wide shift register of DEPTH stages; async reset, synchronous clear.
module skew_delay_line #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DEPTH-1:0][DW-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            for (int s = DEPTH-1; s > 0; s--) sr[s] <= sr[s-1];
            sr[0] <= din;
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West/north edge feeder for the NxN output-stationary array: lane skew plus flush/drain sequencing.
// Optional bubble counter output enabled by defining SKEW_FEEDER_PERF_EN.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    output logic [N*DW-1:0] west_data,
    output logic [N*DW-1:0] north_data,
    output logic          flush,
    output logic          busy,
`ifdef SKEW_FEEDER_PERF_EN
    output logic [15:0]   bubble_cnt,
`endif
    output logic          done
);

    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N-2);
    localparam logic [KW-1:0] KLEN_MAX   = KW'(K_MAX);

    feeder_state_e  state_q;
    logic [KW-1:0]  klen_q;
    logic [KW-1:0]  beat_cnt;
    logic [CW-1:0]  drain_cnt;
    logic           accept;
    logic           lane_clr;
    logic [N*DW-1:0] a_in, b_in;

    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign lane_clr = (state_q == FLUSH);

    // Bubbles and non-streaming cycles push zeros so the skew stays aligned.
    assign a_in = accept ? a_col : '0;
    assign b_in = accept ? b_row : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.DW(DW), .DEPTH(i+1)) u_west (
            .clk  (clk),
            .rst  (rst),
            .clr  (lane_clr),
            .din  (a_in[i*DW +: DW]),
            .dout (west_data[i*DW +: DW])
        );
        skew_delay_line #(.DW(DW), .DEPTH(i+1)) u_north (
            .clk  (clk),
            .rst  (rst),
            .clr  (lane_clr),
            .din  (b_in[i*DW +: DW]),
            .dout (north_data[i*DW +: DW])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            klen_q    <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            flush     <= 1'b0;
            done      <= 1'b0;
        end else begin
            flush <= 1'b0;
            done  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        klen_q   <= (k_len > KLEN_MAX) ? KLEN_MAX : k_len;
                        beat_cnt <= '0;
                        flush    <= 1'b1;
                        state_q  <= FLUSH;
                    end
                end
                FLUSH: begin
                    drain_cnt <= '0;
                    if (klen_q == '0) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_cnt <= KW'(beat_cnt + 1'b1);
                        if (KW'(beat_cnt + 1'b1) == klen_q) begin
                            drain_cnt <= '0;
                            state_q   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Final beat reaches PE(N-1,N-1) 2N-1 edges after its accept.
                    if (drain_cnt == DRAIN_LAST) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drain_cnt <= CW'(drain_cnt + 1'b1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SKEW_FEEDER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (state_q == FLUSH) begin
            bubble_cnt <= '0;
        end else if (state_q == STREAM && !in_valid && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural 4x4 output-stationary array model.
module tb_systolic_skew_feeder;

    localparam int N = 4, DW = 8, K_MAX = 16, KW = $clog2(K_MAX+1);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [N*DW-1:0] a_col = '0, b_row = '0;
    logic in_ready, flush, busy, done;
    logic [N*DW-1:0] west_data, north_data;
`ifdef SKEW_FEEDER_PERF_EN
    logic [15:0] bubble_cnt;
`endif

    int checks = 0, errors = 0, edge_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    systolic_skew_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_col      (a_col),
        .b_row      (b_row),
        .west_data  (west_data),
        .north_data (north_data),
        .flush      (flush),
        .busy       (busy),
`ifdef SKEW_FEEDER_PERF_EN
        .bubble_cnt (bubble_cnt),
`endif
        .done       (done)
    );

    // Output-stationary array: operands hop east/south one PE per edge; flush clears accumulators.
    logic signed [DW-1:0] wpipe [N][N];
    logic signed [DW-1:0] npipe [N][N];
    logic signed [31:0]   acc   [N][N];

    always @(posedge clk) begin : pe_array
        logic signed [DW-1:0] w, n;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w = (j == 0) ? $signed(west_data[i*DW +: DW])  : wpipe[i][(j > 0) ? j-1 : 0];
                n = (i == 0) ? $signed(north_data[j*DW +: DW]) : npipe[(i > 0) ? i-1 : 0][j];
                wpipe[i][j] <= w;
                npipe[i][j] <= n;
                if (flush) acc[i][j] <= 32'sd0;
                else       acc[i][j] <= acc[i][j] + w * n;
            end
        end
    end

    typedef struct {
        int n_acc, c_first, c_last, c_done, c_flush, n_flush, n_rdy, n_bub, w2_edge, bad_vals;
        bit tmo;
    } tile_res_t;

    // Drives one tile from IDLE until done is observed; edges are numbered by edge_no.
    task automatic run_tile(input int klen, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                            input int bub_pct, input bit poke_start, output tile_res_t r);
        int keff;
        keff = (klen > K_MAX) ? K_MAX : klen;
        r.n_acc = 0; r.c_first = -1; r.c_last = -1; r.c_done = -1; r.c_flush = -1;
        r.n_flush = 0; r.n_rdy = 0; r.n_bub = 0; r.w2_edge = -1; r.bad_vals = 0; r.tmo = 1'b1;
        @(negedge clk);
        a_col = a; b_row = b; k_len = KW'(klen); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (flush) begin
                r.n_flush++;
                if (r.c_flush < 0) r.c_flush = edge_no;
            end
            if (in_ready) r.n_rdy++;
            for (int i = 0; i < N; i++) begin
                if (west_data[i*DW +: DW] != '0 && west_data[i*DW +: DW] != a[i*DW +: DW]) r.bad_vals++;
                if (north_data[i*DW +: DW] != '0 && north_data[i*DW +: DW] != b[i*DW +: DW]) r.bad_vals++;
            end
            // edge at which the array first consumes a nonzero lane-2 west operand
            if (r.w2_edge < 0 && west_data[2*DW +: DW] != '0) r.w2_edge = edge_no + 1;
            if (done) begin
                r.c_done = edge_no;
                r.tmo = 1'b0;
                break;
            end
            start = poke_start && (r.n_acc == keff) && (r.c_last == edge_no);
            in_valid = (bub_pct == 0) || ($urandom_range(99) >= bub_pct);
            if (in_ready && in_valid) begin
                r.n_acc++;
                if (r.c_first < 0) r.c_first = edge_no + 1;
                r.c_last = edge_no + 1;
            end else if (in_ready) begin
                r.n_bub++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({in_ready, flush, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {in_ready, flush, busy, done}); end
        checks++; if ({west_data, north_data} !== '0) begin errors++; $display("FAIL reset_lanes got %h exp 0", {west_data, north_data}); end
`ifdef SKEW_FEEDER_PERF_EN
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble got %0d exp 0", bubble_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        tile_res_t r;
        run_tile(4, 32'h04030201, 32'h04030201, 0, 1'b0, r);
        checks++; if (r.tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0d exp 0", r.tmo); end
        checks++; if (r.n_acc !== 4) begin errors++; $display("FAIL basic_accepts got %0d exp 4", r.n_acc); end
        checks++; if (r.n_flush !== 1) begin errors++; $display("FAIL basic_flush got %0d exp 1", r.n_flush); end
        checks++; if (r.w2_edge - r.c_first !== 3) begin errors++; $display("FAIL basic_lane2_skew got %0d exp 3", r.w2_edge - r.c_first); end
        checks++; if (r.c_done - r.c_last !== 7) begin errors++; $display("FAIL basic_done_lat got %0d exp 7", r.c_done - r.c_last); end
        checks++; if (r.bad_vals !== 0) begin errors++; $display("FAIL basic_lane_vals got %0d exp 0", r.bad_vals); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++; if (acc[i][j] !== 4*(i+1)*(j+1)) begin errors++; $display("FAIL basic_pe%0d%0d got %0d exp %0d", i, j, acc[i][j], 4*(i+1)*(j+1)); end
            end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse got %b exp 00", {done, busy}); end
    endtask

    task automatic test_bubbles();
        tile_res_t r;
        run_tile(4, 32'h04030201, 32'h04030201, 50, 1'b0, r);
        checks++; if (r.n_acc !== 4) begin errors++; $display("FAIL bubble_accepts got %0d exp 4", r.n_acc); end
        checks++; if (r.c_done - r.c_last !== 7) begin errors++; $display("FAIL bubble_done_lat got %0d exp 7", r.c_done - r.c_last); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++; if (acc[i][j] !== 4*(i+1)*(j+1)) begin errors++; $display("FAIL bubble_pe%0d%0d got %0d exp %0d", i, j, acc[i][j], 4*(i+1)*(j+1)); end
            end
`ifdef SKEW_FEEDER_PERF_EN
        checks++; if (bubble_cnt !== 16'(r.n_bub)) begin errors++; $display("FAIL bubble_cnt got %0d exp %0d", bubble_cnt, r.n_bub); end
`endif
    endtask

    task automatic test_klen_zero();
        tile_res_t r;
        run_tile(0, 32'h11111111, 32'h22222222, 0, 1'b0, r);
        checks++; if (r.tmo !== 1'b0) begin errors++; $display("FAIL k0_timeout got %0d exp 0", r.tmo); end
        checks++; if (r.n_rdy !== 0) begin errors++; $display("FAIL k0_ready got %0d exp 0", r.n_rdy); end
        checks++; if (r.n_flush !== 1) begin errors++; $display("FAIL k0_flush got %0d exp 1", r.n_flush); end
        checks++; if (r.c_done - r.c_flush !== 1) begin errors++; $display("FAIL k0_done_lat got %0d exp 1", r.c_done - r.c_flush); end
    endtask

    task automatic test_klen_clamp();
        tile_res_t r;
        run_tile(31, 32'h04030201, 32'h01020304, 0, 1'b0, r);
        checks++; if (r.n_acc !== 16) begin errors++; $display("FAIL clamp_accepts got %0d exp 16", r.n_acc); end
        checks++; if (r.n_rdy !== 16) begin errors++; $display("FAIL clamp_ready got %0d exp 16", r.n_rdy); end
        checks++; if (acc[3][0] !== 16*4*4) begin errors++; $display("FAIL clamp_pe30 got %0d exp %0d", acc[3][0], 16*4*4); end
        checks++; if (acc[0][3] !== 16*1*1) begin errors++; $display("FAIL clamp_pe03 got %0d exp %0d", acc[0][3], 16); end
    endtask

    task automatic test_signed_extremes();
        tile_res_t r;
        run_tile(16, 32'h80808080, 32'h80808080, 0, 1'b1, r);
        checks++; if (r.c_done - r.c_last !== 7) begin errors++; $display("FAIL signed_done_lat got %0d exp 7", r.c_done - r.c_last); end
        checks++; if (r.bad_vals !== 0 || r.w2_edge < 0) begin errors++; $display("FAIL signed_lane_vals got %0d/%0d exp 0/seen", r.bad_vals, r.w2_edge); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++; if (acc[i][j] !== 262144) begin errors++; $display("FAIL signed_pe%0d%0d got %0d exp 262144", i, j, acc[i][j]); end
            end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL signed_drain_start got busy=%b exp 0", busy); end
        end
    endtask

    task automatic test_reset_mid_stream();
        tile_res_t r;
        int n = 0;
        @(negedge clk);
        a_col = 32'h7F7F7F7F; b_row = 32'h7F7F7F7F; k_len = KW'(8); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50 && n < 3; t++) begin
            in_valid = 1'b1;
            if (in_ready) n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        checks++; if (n !== 3) begin errors++; $display("FAIL midrst_accepts got %0d exp 3", n); end
        @(negedge clk);
        checks++; if ({in_ready, flush, busy, done} !== 4'b0) begin errors++; $display("FAIL midrst_ctrl got %b exp 0000", {in_ready, flush, busy, done}); end
        checks++; if ({west_data, north_data} !== '0) begin errors++; $display("FAIL midrst_lanes got %h exp 0", {west_data, north_data}); end
        rst = 1'b0;
        run_tile(4, 32'h04030201, 32'h04030201, 0, 1'b0, r);
        checks++; if (r.n_flush !== 1) begin errors++; $display("FAIL midrst_flush got %0d exp 1", r.n_flush); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++; if (acc[i][j] !== 4*(i+1)*(j+1)) begin errors++; $display("FAIL midrst_pe%0d%0d got %0d exp %0d", i, j, acc[i][j], 4*(i+1)*(j+1)); end
            end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_klen_zero();
        test_klen_clamp();
        test_signed_extremes();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream edge stage of the NxN output-stationary systolic MAC array.
- Accepts one reduction step per beat: one A column of N signed 8-bit values and one B row of N signed 8-bit values.
- Skews lane i by i cycles and drives the west-edge and north-edge operand inputs of the array.
- Sequences the array's tile flush and signals when every accumulator holds its final result.

Parameters:
- N, 4, array dimension (lanes per edge).
- DW, 8, operand width in bits, signed two's complement.
- K_MAX, 16, maximum reduction length per tile.
- KW, $clog2(K_MAX+1), width of k_len.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  tile start; sampled only in IDLE.
- k_len  in  KW  reduction length; captured with start.
- in_valid  in  1  beat available.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- a_col  in  N*DW  A column; lane i at bits [i*DW +: DW].
- b_row  in  N*DW  B row; lane j at bits [j*DW +: DW].
- west_data  out  N*DW  to the west operand input of row i, column 0; registered.
- north_data  out  N*DW  to the north operand input of row 0, column j; registered.
- flush  out  1  array flush; registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; array results final.

Behaviour:
- Reset values: all outputs 0, state IDLE, all lane registers 0, counters 0. Reset applies immediately, including mid-tile.
- Reset does not clear the PE array. The next tile's FLUSH does that.
- FSM states: IDLE, FLUSH, STREAM, DRAIN, DONE.
- IDLE:
  - in_ready=0; lanes shift zeros.
  - On start: capture klen_q = min(k_len, K_MAX), then go to FLUSH.
- FLUSH (1 cycle):
  - flush=1 during this cycle; lane registers are cleared.
  - klen_q==0 goes to DONE; otherwise goes to STREAM.
- STREAM:
  - in_ready=1 combinationally from state.
  - Accepted beat: lane i of a_col/b_row enters the lane-i delay line of depth i+1 registers. Lane 0 appears on its output 1 cycle after the accepting edge; lane i appears i+1 cycles after.
  - No beat accepted (bubble): zero is inserted on all lanes of both edges. This keeps alignment and contributes 0 to every accumulator.
  - Beat counter increments per accept. The accept that makes count==klen_q moves to DRAIN at that same edge.
- DRAIN:
  - in_ready=0; zeros are shifted in.
  - Counter runs 2N-2 cycles.
  - Last accumulation at PE(N-1,N-1) occurs at edge c+2N-1, where c is the final accepting edge.
- DONE:
  - done=1 for exactly one cycle, registered high from edge c+2N-1, so results are stable while done=1.
  - Then go to IDLE.
  - For klen_q==0: done directly follows the flush cycle.
- start outside IDLE is ignored.
- in_valid outside STREAM is ignored; no beat is consumed.
- Arithmetic: no arithmetic on data; values pass bit-exact, sign preserved.
- Counters are KW bits and $clog2(2N) bits, with no wrap in legal operation.

Optional Feature:
- Macro: SKEW_FEEDER_PERF_EN.
- Defined:
  - Adds output bubble_cnt (16 bits), reset 0, cleared in FLUSH.
  - Increments each STREAM cycle with !in_valid; saturates at 16'hFFFF.
  - Holds its value through DRAIN, DONE and IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package systolic_pkg:
  - DW/N defaults.
  - Operand typedef (signed logic [DW-1:0]).
  - Accumulator width constant (32).
  - Feeder state enum {IDLE, FLUSH, STREAM, DRAIN, DONE}.
- One sub-module, skew_delay_line:
  - Parameter DEPTH; a DW-wide shift register with synchronous clear and async reset.
  - Instantiated 2N times, with DEPTH=i+1 for lane i.

Test Plan:
- Reset mid-STREAM (N=4, after 3 of 8 beats) -> next cycle all outputs 0, busy=0.
  - A following tile gives flush for 1 cycle and correct results.
- N=4, k_len=4, back-to-back beats, a_col lane i = i+1, b_row lane j = j+1 -> lane 2 west value appears exactly 3 cycles after its accept edge.
  - done pulses at edge c+7; PE(i,j) result = 4*(i+1)*(j+1).
- Same tile with random in_valid bubbles (50%) -> identical PE results.
  - done is still 7 cycles after the last accept.
  - With SKEW_FEEDER_PERF_EN, bubble_cnt equals the number of low-valid STREAM cycles.
- k_len=0 -> flush cycle, then done the next cycle; in_ready never high.
- k_len=31 with K_MAX=16 -> exactly 16 beats accepted; in_ready drops after the 16th.
- Signed extremes: all operands -128 for k_len=16 -> every PE result = 262144.
  - west/north outputs carry 8'h80 unchanged.
  - start pulsed during DRAIN is ignored.
